// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG_PATTERN : hex digit -> segment pattern, bit order gfedcba, active-high
//   SEG_BLANK   : pattern with every segment off
//   idx_w()     : scan index width for a given digit count (never zero)
//   addr_w()    : write-address width; one bit wider than the index so that
//                 every out-of-range digit number can be presented and ignored
package sseg_pkg;

    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int n);
        return idx_w(n) + 1;
    endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// Bus between a controller and the scan driver.
//   Step               : external advance strobe (driver input)
//   Wr_En/Wr_Addr/...  : single-digit write port (driver inputs)
//   SSEG_Data/SSEG_DP  : registered segment and decimal-point outputs
//   Anode              : registered one-hot digit enable, bit 0 = leftmost
//   Slot_Wrap          : one-cycle pulse when the scan index returns to 0
// master = controller side, slave = scan driver side.
interface sseg_scan_mux_if
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 2
);
    localparam int ADDR_W = addr_w(NUM_DIGITS);

    logic                  Step;
    logic                  Wr_En;
    logic [ADDR_W-1:0]     Wr_Addr;
    logic [3:0]            Wr_Val;
    logic                  Wr_DP;
    logic                  Wr_Blank;
    logic [6:0]            SSEG_Data;
    logic                  SSEG_DP;
    logic [NUM_DIGITS-1:0] Anode;
    logic                  Slot_Wrap;

    modport master (
        output Step, Wr_En, Wr_Addr, Wr_Val, Wr_DP, Wr_Blank,
        input  SSEG_Data, SSEG_DP, Anode, Slot_Wrap
    );

    modport slave (
        input  Step, Wr_En, Wr_Addr, Wr_Val, Wr_DP, Wr_Blank,
        output SSEG_Data, SSEG_DP, Anode, Slot_Wrap
    );

endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational hex to seven-segment lookup.
//   val : hex digit 0..F
//   seg : segment pattern gfedcba, active-high
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = SEG_PATTERN[val];

endmodule

// File: rtl/sseg_scan_mux.sv
// N-digit seven-segment scan driver with anti-ghosting.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : slave side of sseg_scan_mux_if (step strobe, digit write port,
//              registered segment/DP/anode outputs, wrap pulse)
// Digits are visited round-robin, one slot per advance tick. After every tick
// the anodes and segments are held off for GHOST_CYCLES cycles so the
// previous digit's pattern never bleeds onto the next digit.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 50000,
    parameter int GHOST_CYCLES = 4,
    parameter int EXT_STEP     = 0
) (
    input  logic           CLK,
    input  logic           RST,
    sseg_scan_mux_if.slave bus
);

    localparam int IDX_W  = idx_w(NUM_DIGITS);
    localparam int ADDR_W = addr_w(NUM_DIGITS);
    localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int GH_W   = (GHOST_CYCLES > 0) ? $clog2(GHOST_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;
    logic [GH_W-1:0]       ghost;
    logic [3:0]            val_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_q;
    logic [NUM_DIGITS-1:0] blank_q;

    logic                  presc_tick;
    logic                  tick;
    logic                  wr_ok;
    logic [IDX_W-1:0]      wr_idx;
    logic [6:0]            seg_cur;

    logic [NUM_DIGITS-1:0] anode_p1;
    logic [6:0]            seg_p1;
    logic                  dp_p1;
    logic                  wrap_p1;

    // The prescaler free-runs in both modes; only the tick source changes.
    assign presc_tick = (presc == PRE_W'(REFRESH_DIV - 1));
    assign tick       = (EXT_STEP != 0) ? bus.Step : presc_tick;

    assign wr_ok  = bus.Wr_En && (bus.Wr_Addr < ADDR_W'(NUM_DIGITS));
    assign wr_idx = bus.Wr_Addr[IDX_W-1:0];

    sseg_hex_decode u_dec (
        .val (val_q[idx]),
        .seg (seg_cur)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc    <= '0;
            idx      <= '0;
            ghost    <= '0;
            dp_q     <= '0;
            blank_q  <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                val_q[i] <= '0;
            end
            anode_p1 <= '0;
            seg_p1   <= SEG_BLANK;
            dp_p1    <= 1'b0;
            wrap_p1  <= 1'b0;
        end else begin
            // Stage 0: scan state and digit registers
            presc <= presc_tick ? '0 : presc + 1'b1;

            if (tick) begin
                idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                // A tick inside a running window simply restarts it.
                ghost <= GH_W'(GHOST_CYCLES);
            end else if (ghost != '0) begin
                ghost <= ghost - 1'b1;
            end

            if (wr_ok) begin
                val_q[wr_idx]   <= bus.Wr_Val;
                dp_q[wr_idx]    <= bus.Wr_DP;
                blank_q[wr_idx] <= bus.Wr_Blank;
            end

            // Stage 1: output registers, built from the current stage-0 state
            wrap_p1  <= tick && (idx == LAST_IDX);
            anode_p1 <= (ghost == '0) ? (ONE_HOT0 << idx) : '0;
            seg_p1   <= ((ghost == '0) && !blank_q[idx]) ? seg_cur : SEG_BLANK;
            dp_p1    <= dp_q[idx] & ~blank_q[idx];
        end
    end

    assign bus.Anode     = anode_p1;
    assign bus.SSEG_Data = seg_p1;
    assign bus.SSEG_DP   = dp_p1;
    assign bus.Slot_Wrap = wrap_p1;

endmodule

// File: tb/tb_sseg_scan_mux.sv
module tb_sseg_scan_mux;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 2;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       wrap;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       step;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_val;
    logic       wr_dp;
    logic       wr_blank;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb [$];

    // reference tables written straight from the digit decode list
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] an_exp  [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [6:0] sq_exp  [5]  = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h06};

    // behavioural model state, [0] = prescaled DUT, [1] = external-step DUT
    int         m_idx   [2];
    int         m_ghost [2];
    int         m_presc [2];
    logic [3:0] m_val   [2][ND];
    logic       m_dp    [2][ND];
    logic       m_blank [2][ND];

    always #5 CLK = ~CLK;

    sseg_scan_mux_if #(.NUM_DIGITS(ND)) bus0 ();
    sseg_scan_mux_if #(.NUM_DIGITS(ND)) bus1 ();

    assign bus0.Step = step;  assign bus1.Step = step;
    assign bus0.Wr_En = wr_en; assign bus1.Wr_En = wr_en;
    assign bus0.Wr_Addr = wr_addr; assign bus1.Wr_Addr = wr_addr;
    assign bus0.Wr_Val = wr_val; assign bus1.Wr_Val = wr_val;
    assign bus0.Wr_DP = wr_dp; assign bus1.Wr_DP = wr_dp;
    assign bus0.Wr_Blank = wr_blank; assign bus1.Wr_Blank = wr_blank;

    sseg_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GHOST_CYCLES(GC), .EXT_STEP(0)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    sseg_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GHOST_CYCLES(GC), .EXT_STEP(1)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: predict the outputs each DUT must present after this edge,
    // queue them, clock, then pop and compare.
    task automatic cycle();
        exp_t e;
        bit   tk;
        for (int k = 0; k < 2; k++) begin
            e.k = k;
            if (RST) begin
                e.an = '0; e.seg = '0; e.dp = 1'b0; e.wrap = 1'b0;
                m_idx[k] = 0; m_ghost[k] = 0; m_presc[k] = 0;
                for (int d = 0; d < ND; d++) begin
                    m_val[k][d] = '0; m_dp[k][d] = 1'b0; m_blank[k][d] = 1'b1;
                end
            end else begin
                tk     = (k == 1) ? step : (m_presc[k] == RD - 1);
                e.an   = (m_ghost[k] == 0) ? 4'(1 << m_idx[k]) : 4'b0000;
                e.seg  = (m_ghost[k] == 0 && !m_blank[k][m_idx[k]]) ? seg_tab[m_val[k][m_idx[k]]] : 7'h00;
                e.dp   = m_dp[k][m_idx[k]] & ~m_blank[k][m_idx[k]];
                e.wrap = tk && (m_idx[k] == ND - 1);
                m_presc[k] = (m_presc[k] == RD - 1) ? 0 : m_presc[k] + 1;
                if (tk) begin
                    m_idx[k]   = (m_idx[k] + 1) % ND;
                    m_ghost[k] = GC;
                end else if (m_ghost[k] > 0) begin
                    m_ghost[k]--;
                end
                if (wr_en && wr_addr < ND) begin
                    m_val[k][wr_addr]   = wr_val;
                    m_dp[k][wr_addr]    = wr_dp;
                    m_blank[k][wr_addr] = wr_blank;
                end
            end
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.k == 0) begin
                chk("sb0_anode", bus0.Anode, e.an);
                chk("sb0_seg", bus0.SSEG_Data, e.seg);
                chk("sb0_dp", bus0.SSEG_DP, e.dp);
                chk("sb0_wrap", bus0.Slot_Wrap, e.wrap);
            end else begin
                chk("sb1_anode", bus1.Anode, e.an);
                chk("sb1_seg", bus1.SSEG_Data, e.seg);
                chk("sb1_dp", bus1.SSEG_DP, e.dp);
                chk("sb1_wrap", bus1.Slot_Wrap, e.wrap);
            end
        end
    endtask

    // Wait (bounded) until DUT0's anode switches on to the given pattern.
    task automatic wait_appear0(input logic [3:0] pat, input string tag);
        logic [3:0] prev;
        bit         seen;
        prev = bus0.Anode;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cycle();
            if (prev == 4'b0000 && bus0.Anode == pat) seen = 1'b1;
            prev = bus0.Anode;
        end
        chk(tag, seen, 1'b1);
    endtask

    initial begin
        logic [3:0] prev;
        int         app, zeros, since, wraps;
        bit         found;

        RST = 1'b1; step = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_val = '0; wr_dp = 1'b0; wr_blank = 1'b0;

        // reset held two cycles
        cycle();
        cycle();
        chk("rst_anode", bus0.Anode, 4'b0000);
        chk("rst_seg", bus0.SSEG_Data, 7'h00);
        chk("rst_dp", bus0.SSEG_DP, 1'b0);
        chk("rst_wrap", bus0.Slot_Wrap, 1'b0);

        RST = 1'b0;
        cycle();
        chk("rel_anode", bus0.Anode, 4'b0001);
        chk("rel_seg_blank", bus0.SSEG_Data, 7'h00);

        // load digits 1,2,3,4
        for (int d = 0; d < ND; d++) begin
            wr_en = 1'b1; wr_addr = 3'(d); wr_val = 4'(d + 1); wr_dp = 1'b0; wr_blank = 1'b0;
            cycle();
        end
        wr_en = 1'b0;

        // synchronise on a wrap, then capture five digit appearances
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            cycle();
            if (bus0.Slot_Wrap) found = 1'b1;
        end
        chk("wrap_seen", found, 1'b1);

        prev = bus0.Anode; app = 0; zeros = 0; since = 0; wraps = 0;
        for (int i = 0; i < 64 && app < 5; i++) begin
            cycle();
            since++;
            if (bus0.Slot_Wrap && app > 0) wraps++;
            if (bus0.Anode == 4'b0000) begin
                zeros++;
            end else if (prev == 4'b0000) begin
                chk("scan_anode", bus0.Anode, an_exp[app]);
                chk("scan_seg", bus0.SSEG_Data, sq_exp[app]);
                chk("ghost_len", zeros, GC);
                if (app > 0) chk("slot_len", since, RD);
                since = 0; zeros = 0; app++;
            end
            prev = bus0.Anode;
        end
        chk("scan_apps", app, 5);
        chk("wrap_count", wraps, 1);

        // overwrite the digit on display
        wait_appear0(4'b0100, "wait_digit2");
        wr_en = 1'b1; wr_addr = 3'd2; wr_val = 4'hE; wr_dp = 1'b1; wr_blank = 1'b0;
        cycle();
        wr_en = 1'b0;
        cycle();
        chk("wr_live_seg", bus0.SSEG_Data, 7'h79);
        chk("wr_live_dp", bus0.SSEG_DP, 1'b1);
        chk("wr_live_anode", bus0.Anode, 4'b0100);

        // out-of-range address: low bits alias digit 1, which must stay "2"
        wr_en = 1'b1; wr_addr = 3'd5; wr_val = 4'h8; wr_dp = 1'b1; wr_blank = 1'b0;
        cycle();
        wr_en = 1'b0;
        wait_appear0(4'b0010, "wait_digit1");
        chk("bad_addr_seg", bus0.SSEG_Data, 7'h5B);
        chk("bad_addr_dp", bus0.SSEG_DP, 1'b0);

        // external-step DUT has seen no Step pulse for well over 100 cycles
        chk("ext_hold_anode", bus1.Anode, 4'b0001);
        chk("ext_hold_seg", bus1.SSEG_Data, 7'h06);

        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            cycle();
            step = 1'b0;
            repeat (4) cycle();
        end
        chk("ext_3_anode", bus1.Anode, 4'b1000);
        chk("ext_3_seg", bus1.SSEG_Data, 7'h66);

        step = 1'b1;
        cycle();
        chk("ext_held_wrap", bus1.Slot_Wrap, 1'b1);
        cycle();
        chk("ext_held_nowrap", bus1.Slot_Wrap, 1'b0);
        step = 1'b0;
        repeat (4) cycle();
        chk("ext_held_anode", bus1.Anode, 4'b0010);
        chk("ext_held_seg", bus1.SSEG_Data, 7'h5B);

        // reset inside a ghost window of DUT0
        prev = bus0.Anode;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            cycle();
            if (prev != 4'b0000 && bus0.Anode == 4'b0000) found = 1'b1;
            prev = bus0.Anode;
        end
        chk("ghost_entry", found, 1'b1);
        RST = 1'b1;
        cycle();
        chk("mid_rst_anode0", bus0.Anode, 4'b0000);
        chk("mid_rst_seg0", bus0.SSEG_Data, 7'h00);
        chk("mid_rst_anode1", bus1.Anode, 4'b0000);
        RST = 1'b0;
        cycle();
        chk("post_rst_anode0", bus0.Anode, 4'b0001);
        chk("post_rst_seg0", bus0.SSEG_Data, 7'h00);
        chk("post_rst_anode1", bus1.Anode, 4'b0001);
        repeat (10) cycle();
        chk("post_rst_blank", bus0.SSEG_Data, 7'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
